// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle sll/srl/sra/pass unit shifting one bit per clock with start/busy/done handshake
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, result_n, shifted;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic [1:0] op_q, op_n;
  logic done_n;
  assign busy = state == SHIFT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      result <= result_n;
      done   <= done_n;
    end
  end
  // pass-through never shifts because its count is forced to zero
  always_comb begin
    shifted  = op_q == 2'b00 ? {acc[WIDTH-2:0], 1'b0}
                             : {op_q == 2'b10 & acc[WIDTH-1], acc[WIDTH-1:1]};
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    op_n     = op_q;
    result_n = result;
    done_n   = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = SHIFT;
        acc_n   = data_in;
        op_n    = op;
        cnt_n   = op == 2'b11 ? '0 : shamt_in[SHAMT_W-1:0];
      end
    end else if (cnt == '0) begin
      result_n = acc;
      done_n   = 1'b1;
      state_n  = IDLE;
    end else begin
      acc_n = shifted;
      cnt_n = cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed checks of seq_shifter against a plain-arithmetic model
module tb_seq_shifter;
  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [1:0] op;
  logic [31:0] data_in, shamt_in, result;
  int checks = 0;
  int errors = 0;

  seq_shifter dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
    .shamt_in(shamt_in), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int n);
    case (o)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return $unsigned($signed(d) >>> n);
      default: return d;
    endcase
  endfunction

  // drive a start for exactly one active edge; returns one time unit after that edge
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [31:0] s);
    start = 1'b1; op = o; data_in = d; shamt_in = s;
    @(posedge clk);
    #1 start = 1'b0; op = 2'($urandom); data_in = $urandom; shamt_in = $urandom;
  endtask

  // lat = edges after the start edge until done is seen (-1 on timeout)
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j - 1;
        return;
      end
      busy_cyc += int'(busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; data_in = '0; shamt_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, result} !== 34'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  t_op  [6] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [31:0] t_d   [6] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hDEAD_BEEF};
    logic [31:0] t_s   [6] = '{32'd5, 32'd31, 32'd31, 32'h24, 32'd0, 32'd7};
    logic [31:0] t_r   [6] = '{32'h20, 32'hFFFF_FFFF, 32'h1, 32'h0F00_0000, 32'hF000_0000, 32'hDEAD_BEEF};
    int          t_lat [6] = '{6, 32, 32, 5, 1, 1};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(t_op[i], t_d[i], t_s[i]);
      wait_done(lat, bc);
      checks++;
      if (lat !== t_lat[i] || bc !== t_lat[i]) begin
        errors++;
        $display("FAIL directed%0d_latency: lat=%0d busy=%0d, want %0d", i, lat, bc, t_lat[i]);
      end
      checks++;
      if (result !== t_r[i]) begin
        errors++;
        $display("FAIL directed%0d_result: got %h, want %h", i, result, t_r[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== t_r[i]) begin
        errors++;
        $display("FAIL directed%0d_pulse: done=%b result=%h, want 0 %h", i, done, result, t_r[i]);
      end
    end
  endtask

  task automatic test_random;
    int lat, bc, n;
    logic [1:0] o;
    logic [31:0] d, s;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom); d = $urandom; s = $urandom;
      n = (o == 2'b11) ? 0 : int'(s % 32);
      @(negedge clk);
      issue(o, d, s);
      wait_done(lat, bc);
      checks++;
      if (lat !== n + 1 || bc !== n + 1 || result !== model(o, d, n)) begin
        errors++;
        $display("FAIL random%0d op=%0d d=%h s=%h: lat=%0d busy=%0d result=%h, want lat=%0d result=%h",
                 i, o, d, s, lat, bc, result, n + 1, model(o, d, n));
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, extra;
    @(negedge clk);
    issue(2'b01, 32'hF000_0000, 32'd10);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1; op = 2'b00; data_in = 32'h1; shamt_in = 32'd3;
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat < 0 || result !== 32'h003C_0000) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d result=%h, want 003c0000", lat, result);
    end
    issue(2'b00, 32'h1, 32'd3);
    checks++;
    if (result !== 32'h003C_0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b result=%h, want 1 003c0000", busy, result);
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 4 || result !== 32'h8) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d result=%h, want 4 00000008", lat, result);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      extra += int'(done);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL single_pulse: %0d extra done cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, pulses;
    logic [31:0] d;
    @(negedge clk);
    issue(2'b00, 32'hFFFF_FFFF, 32'd20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, result} !== 34'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      pulses += int'(done);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_abort: %0d done cycles after abort, want 0", pulses);
    end
    d = $urandom;
    issue(2'b10, d, 32'd9);
    wait_done(lat, bc);
    checks++;
    if (lat !== 10 || result !== model(2'b10, d, 9)) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d result=%h, want 10 %h", lat, result, model(2'b10, d, 9));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
